geofence_result_collector: RTL and testbench
============================================

GEOFENCE_RESULT_COLLECTOR -- requirements
Module: geofence_result_collector

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH, 8, result FIFO entries (power of 2, >=2)
- ID_W, 8, frame-id width
- CNT_W, 16, statistics counter width
- TIMEOUT, 1023, idle cycles before the watchdog fires
REQ-002 The design SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, rising-edge clock
- reset, in, 1, synchronous active-high reset
- gf_valid, in, 1, one-cycle result strobe from the geofence stage
- gf_is_inside, in, 1, geofence verdict, qualified by gf_valid
- clr, in, 1, synchronous soft clear
- res_ready, in, 1, consumer accepts the head entry
- res_valid, out, 1, FIFO non-empty
- res_inside, out, 1, head-entry verdict
- res_id, out, ID_W, head-entry frame id
- fifo_level, out, log2(DEPTH)+1, current occupancy
- frame_cnt, out, CNT_W, frames seen, including dropped frames
- inside_cnt, out, CNT_W, accepted frames with verdict 1
- drop_cnt, out, CNT_W, frames dropped on full
- overflow, out, 1, sticky: at least one drop
- timeout, out, 1, sticky: watchdog expired

Function
REQ-004 A push SHALL occur when gf_valid=1, clr=0, and the FIFO is not full, or is full with a pop in the same cycle; the entry is {next_id, gf_is_inside}.
REQ-005 A pop SHALL occur when res_valid=1 and res_ready=1; res_ready with an empty FIFO has no effect.
REQ-006 The FIFO SHALL be first-word fall-through: the entry appears on res_valid/res_inside/res_id one cycle after its gf_valid cycle when the FIFO was empty.
REQ-007 res_inside and res_id SHALL hold stable while res_valid=1 and res_ready=0.
REQ-008 Simultaneous push and pop SHALL leave fifo_level unchanged, at any level including 0 and DEPTH.
REQ-009 next_id SHALL increment by 1 on every gf_valid with clr=0, whether accepted or dropped, wrapping from 2^ID_W-1 to 0.
REQ-010 On gf_valid with a full FIFO and no pop:
- the entry is discarded
- drop_cnt increments
- overflow is set
- FIFO contents are unchanged
REQ-011 frame_cnt, inside_cnt, and drop_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-012 inside_cnt SHALL increment only on accepted pushes with gf_is_inside=1.
REQ-013 The watchdog SHALL be a 2-state FSM:
- ARMED: counts idle cycles.
- EXPIRED: timeout=1.
REQ-014 In ARMED, the idle counter SHALL reset to 0 on gf_valid and otherwise increment.
REQ-015 When the idle counter reaches TIMEOUT, the FSM SHALL move ARMED->EXPIRED on the next edge.
REQ-016 EXPIRED SHALL be left only by reset or clr; gf_valid in EXPIRED is still collected normally.
REQ-017 clr=1 SHALL, on the next edge:
- empty the FIFO
- zero all counters and next_id
- clear overflow and timeout
- return the FSM to ARMED with the idle count at 0
REQ-018 clr SHALL take priority over gf_valid and res_ready in the same cycle; that event is neither stored nor counted.
REQ-019 gf_is_inside SHALL be ignored when gf_valid=0.

Reset
REQ-020 With reset=1 at an edge, the block SHALL load the same state as clr, giving these output values:
- res_valid=0, res_inside=0, res_id=0
- fifo_level=0
- all counters 0
- overflow=0, timeout=0
- FSM=ARMED
REQ-021 reset SHALL take priority over clr and all other inputs.
REQ-022 A reset asserted mid-operation SHALL discard all buffered entries with no partial pop.

Verification
REQ-023 Single frame: gf_valid=1, gf_is_inside=1 at cycle 10, res_ready=0 -> at cycle 11: res_valid=1, res_id=0, res_inside=1, fifo_level=1, frame_cnt=1, inside_cnt=1.
REQ-024 Overflow: 10 strobes with res_ready=0 and DEPTH=8 -> fifo_level=8, frame_cnt=10, drop_cnt=2, overflow=1; draining yields ids 0..7 in order.
REQ-025 Full with simultaneous push and pop: FIFO full, gf_valid and res_ready high in the same cycle -> no drop, level stays 8, new id appears at the tail.
REQ-026 Watchdog: no gf_valid for TIMEOUT+1 cycles after reset -> timeout=1; a later gf_valid does not clear it; clr clears it.
REQ-027 Clear collision: clr and gf_valid in the same cycle with 3 entries buffered -> level 0, frame_cnt 0; the next strobe gets res_id=0.
REQ-028 Id wrap: 257 strobes with ID_W=8 and res_ready=1 -> the last popped res_id is 0.

Source files
------------

// File: rtl/geofence_result_collector.sv
// Geofence result collector: buffers per-frame verdicts with frame ids, keeps stats and an idle watchdog.
// Latency: an entry is visible on res_* one cycle after its gf_valid strobe into an empty FIFO.
// Backpressure: res_valid/res_ready handshake; strobes arriving on a full FIFO without a pop are dropped and counted.

module geofence_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end
endmodule

module geofence_result_collector #(
    parameter int DEPTH   = 8,
    parameter int ID_W    = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   gf_valid,
    input  logic                   gf_is_inside,
    input  logic                   clr,
    input  logic                   res_ready,
    output logic                   res_valid,
    output logic                   res_inside,
    output logic [ID_W-1:0]        res_id,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       frame_cnt,
    output logic [CNT_W-1:0]       inside_cnt,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic                   overflow,
    output logic                   timeout
);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        ARMED,
        EXPIRED
    } wd_state_t;

    wd_state_t       wd_state;
    wd_state_t       wd_state_nxt;
    logic [IW-1:0]   idle_cnt;
    logic [IW-1:0]   idle_cnt_nxt;

    logic [ID_W-1:0] next_id;
    logic            strobe;
    logic            push;
    logic            pop;
    logic            drop;
    logic            fifo_empty;
    logic            fifo_full;
    logic [ID_W:0]   fifo_dout;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // clr wins over every other input in the same cycle.
    assign strobe = gf_valid && !clr;
    assign pop    = !fifo_empty && res_ready && !clr;
    assign push   = strobe && (!fifo_full || pop);
    assign drop   = strobe && fifo_full && !pop;

    geofence_fifo #(
        .W     (ID_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   ({next_id, gf_is_inside}),
        .dout  (fifo_dout),
        .level (fifo_level),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Head fields are forced to zero when empty so stale storage never leaks out.
    assign res_valid  = !fifo_empty;
    assign res_inside = res_valid ? fifo_dout[0] : 1'b0;
    assign res_id     = res_valid ? fifo_dout[ID_W:1] : '0;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            next_id    <= '0;
            frame_cnt  <= '0;
            inside_cnt <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (strobe) begin
                next_id   <= next_id + 1'b1;
                frame_cnt <= sat_inc(frame_cnt);
            end
            if (push && gf_is_inside) begin
                inside_cnt <= sat_inc(inside_cnt);
            end
            if (drop) begin
                drop_cnt <= sat_inc(drop_cnt);
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wd_state <= ARMED;
            idle_cnt <= '0;
        end else begin
            wd_state <= wd_state_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

    always_comb begin
        wd_state_nxt = wd_state;
        idle_cnt_nxt = idle_cnt;
        timeout      = 1'b0;
        case (wd_state)
            ARMED: begin
                if (idle_cnt == IW'(TIMEOUT)) begin
                    wd_state_nxt = EXPIRED;
                end
                if (gf_valid) begin
                    idle_cnt_nxt = '0;
                end else if (idle_cnt != IW'(TIMEOUT)) begin
                    idle_cnt_nxt = idle_cnt + 1'b1;
                end
            end
            EXPIRED: begin
                timeout = 1'b1;
            end
            default: begin
                wd_state_nxt = ARMED;
            end
        endcase
    end
endmodule

// File: tb/tb_geofence_result_collector.sv
// Directed bench for geofence_result_collector: vector table plus multi-cycle corner sequences.
module tb_geofence_result_collector;
    localparam int DEPTH   = 8;
    localparam int ID_W    = 8;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 30;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   gf_valid;
    logic                   gf_is_inside;
    logic                   clr;
    logic                   res_ready;
    logic                   res_valid;
    logic                   res_inside;
    logic [ID_W-1:0]        res_id;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [CNT_W-1:0]       frame_cnt;
    logic [CNT_W-1:0]       inside_cnt;
    logic [CNT_W-1:0]       drop_cnt;
    logic                   overflow;
    logic                   timeout;

    int total = 0;
    int bad   = 0;

    geofence_result_collector #(
        .DEPTH   (DEPTH),
        .ID_W    (ID_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .gf_valid     (gf_valid),
        .gf_is_inside (gf_is_inside),
        .clr          (clr),
        .res_ready    (res_ready),
        .res_valid    (res_valid),
        .res_inside   (res_inside),
        .res_id       (res_id),
        .fifo_level   (fifo_level),
        .frame_cnt    (frame_cnt),
        .inside_cnt   (inside_cnt),
        .drop_cnt     (drop_cnt),
        .overflow     (overflow),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v;
        logic ins;
        logic c;
        logic rdy;
        int   ev;
        int   ei;
        int   eid;
        int   elvl;
        int   efrm;
        int   eins;
        int   edrop;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ins, input logic c, input logic rdy);
        gf_valid     = v;
        gf_is_inside = ins;
        clr          = c;
        res_ready    = rdy;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < n; k++) step();
    endtask

    int exp_ids [8];

    initial begin
        //            v  ins c  rdy  ev ei id lvl frm ins drop
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 0, 1, 1, 1, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 0, 2, 2, 1, 0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 1, 1, 2, 1, 0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1, 2, 1, 3, 2, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 3, 2, 0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 3, 2, 0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 3, 2, 0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 3, 1, 4, 2, 0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 0, 1, 1, 1, 0};

        // Reset state
        do_reset();
        chk("rst res_valid", int'(res_valid), 0);
        chk("rst res_inside", int'(res_inside), 0);
        chk("rst res_id", int'(res_id), 0);
        chk("rst level", int'(fifo_level), 0);
        chk("rst frame_cnt", int'(frame_cnt), 0);
        chk("rst inside_cnt", int'(inside_cnt), 0);
        chk("rst drop_cnt", int'(drop_cnt), 0);
        chk("rst overflow", int'(overflow), 0);
        chk("rst timeout", int'(timeout), 0);

        // Single frame after ten idle cycles
        idle(10);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk("single res_valid", int'(res_valid), 1);
        chk("single res_id", int'(res_id), 0);
        chk("single res_inside", int'(res_inside), 1);
        chk("single level", int'(fifo_level), 1);
        chk("single frame_cnt", int'(frame_cnt), 1);
        chk("single inside_cnt", int'(inside_cnt), 1);

        // Vector table
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].ins, tbl[i].c, tbl[i].rdy);
            step();
            chk($sformatf("vec%0d res_valid", i), int'(res_valid), tbl[i].ev);
            chk($sformatf("vec%0d res_inside", i), int'(res_inside), tbl[i].ei);
            chk($sformatf("vec%0d res_id", i), int'(res_id), tbl[i].eid);
            chk($sformatf("vec%0d level", i), int'(fifo_level), tbl[i].elvl);
            chk($sformatf("vec%0d frame_cnt", i), int'(frame_cnt), tbl[i].efrm);
            chk($sformatf("vec%0d inside_cnt", i), int'(inside_cnt), tbl[i].eins);
            chk($sformatf("vec%0d drop_cnt", i), int'(drop_cnt), tbl[i].edrop);
        end

        // Overflow: ten strobes into an 8-deep FIFO
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) step();
        chk("ovf level", int'(fifo_level), 8);
        chk("ovf frame_cnt", int'(frame_cnt), 10);
        chk("ovf inside_cnt", int'(inside_cnt), 8);
        chk("ovf drop_cnt", int'(drop_cnt), 2);
        chk("ovf overflow", int'(overflow), 1);
        chk("ovf head id", int'(res_id), 0);

        // Full with simultaneous push and pop: id 10 goes to the tail
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        step();
        chk("fullpp level", int'(fifo_level), 8);
        chk("fullpp drop_cnt", int'(drop_cnt), 2);
        chk("fullpp frame_cnt", int'(frame_cnt), 11);
        exp_ids = '{1, 2, 3, 4, 5, 6, 7, 10};
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d id", i), int'(res_id), exp_ids[i]);
            chk($sformatf("drain%0d inside", i), int'(res_inside), (i == 7) ? 0 : 1);
            step();
        end
        chk("drain level", int'(fifo_level), 0);
        chk("drain res_valid", int'(res_valid), 0);
        chk("drain overflow sticky", int'(overflow), 1);

        // Reset mid-operation discards everything
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step();
        chk("midrst pre level", int'(fifo_level), 3);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst level", int'(fifo_level), 0);
        chk("midrst res_valid", int'(res_valid), 0);
        chk("midrst overflow", int'(overflow), 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk("midrst next id", int'(res_id), 0);
        chk("midrst frame_cnt", int'(frame_cnt), 1);

        // Clear collision with three entries buffered
        step();
        step();
        chk("clrcol pre level", int'(fifo_level), 3);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        step();
        chk("clrcol level", int'(fifo_level), 0);
        chk("clrcol frame_cnt", int'(frame_cnt), 0);
        chk("clrcol inside_cnt", int'(inside_cnt), 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("clrcol next id", int'(res_id), 0);
        chk("clrcol next valid", int'(res_valid), 1);

        // Watchdog
        do_reset();
        idle(TIMEOUT);
        chk("wd at limit", int'(timeout), 0);
        idle(1);
        chk("wd expired", int'(timeout), 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk("wd sticky", int'(timeout), 1);
        chk("wd collect level", int'(fifo_level), 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk("wd clr", int'(timeout), 0);
        chk("wd clr level", int'(fifo_level), 0);
        idle(20);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        step();
        idle(TIMEOUT - 1);
        chk("wd rearm limit", int'(timeout), 0);
        idle(1);
        chk("wd rearm at limit", int'(timeout), 0);
        idle(1);
        chk("wd rearm expired", int'(timeout), 1);

        // Id wrap and counter saturation: 257 strobes with the consumer always ready
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        step();
        chk("wrap first id", int'(res_id), 0);
        for (int k = 1; k < 257; k++) step();
        chk("wrap last id", int'(res_id), 0);
        chk("wrap level", int'(fifo_level), 1);
        chk("wrap frame sat", int'(frame_cnt), 255);
        chk("wrap inside sat", int'(inside_cnt), 255);
        chk("wrap drop_cnt", int'(drop_cnt), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk("wrap final level", int'(fifo_level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
